// File: rtl/dbg_console_if.sv
// Control/debug link between the board-side debug console (master) and the CPU core (slave):
// clock enable and scan indices out, halt, WB trace flags and scan read data back.
interface dbg_console_if #(
    parameter int DmWordBits = 10
);
    logic                  cpu_en;
    logic [4:0]            dbg_rf_req;
    logic [DmWordBits-1:0] dbg_dm_addr;
    logic                  cpu_halt;
    logic                  cpu_is_jump;
    logic                  cpu_branched;
    logic                  cpu_is_nop;
    logic [31:0]           cpu_display;
    logic [31:0]           cpu_rf_data;
    logic [31:0]           cpu_dm_data;

    modport master (
        output cpu_en, dbg_rf_req, dbg_dm_addr,
        input  cpu_halt, cpu_is_jump, cpu_branched, cpu_is_nop,
        input  cpu_display, cpu_rf_data, cpu_dm_data
    );

    modport slave (
        input  cpu_en, dbg_rf_req, dbg_dm_addr,
        output cpu_halt, cpu_is_jump, cpu_branched, cpu_is_nop,
        output cpu_display, cpu_rf_data, cpu_dm_data
    );
endinterface

// File: rtl/dbg_console.sv
// Debug console: run/pause/step/halt control of the core's enable, register/memory scan and a
// registered seven-segment mux. Define DBG_STAT_CNT_EN to build the four trace statistics counters.
module dbg_console #(
    parameter int DmWordBits = 10,
    parameter int StatBits   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_run,
    input  logic         btn_step,
    input  logic         btn_next,
    input  logic [1:0]   sel_mode,
    dbg_console_if.master bus,
    output logic [31:0]  disp_value,
    output logic [7:0]   disp_tag,
    output logic         halted
);

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_CORE = 2'd0,
        MODE_RF   = 2'd1,
        MODE_DM   = 2'd2,
        MODE_STAT = 2'd3
    } mode_e;

    state_e                state_q, state_d;
    mode_e                 mode_q;
    logic                  cpu_en;
    logic [4:0]            rf_req_q;
    logic [DmWordBits-1:0] dm_addr_q;
    logic [1:0]            stat_idx_q;
    logic [31:0]           stat_value;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PAUSE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PAUSE: begin
                if (btn_run) begin
                    state_d = ST_RUN;
                end else if (btn_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (bus.cpu_halt) begin
                    state_d = ST_HALTED;
                end else if (btn_run) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_STEP: begin
                state_d = bus.cpu_halt ? ST_HALTED : ST_PAUSE;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_PAUSE;
            end
        endcase
    end

    // Halt gates the enable combinationally so the core never advances past the halting instruction.
    assign cpu_en = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bus.cpu_halt;
    assign halted = (state_q == ST_HALTED);

    assign bus.cpu_en      = cpu_en;
    assign bus.dbg_rf_req  = rf_req_q;
    assign bus.dbg_dm_addr = dm_addr_q;

    // btn_next acts on the mode of the previous cycle, so a press coinciding with a mode change
    // still advances the index of the mode being left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_CORE;
            rf_req_q   <= '0;
            dm_addr_q  <= '0;
            stat_idx_q <= '0;
        end else begin
            mode_q <= mode_e'(sel_mode);
            if (btn_next) begin
                case (mode_q)
                    MODE_RF:   rf_req_q   <= rf_req_q + 5'd1;
                    MODE_DM:   dm_addr_q  <= dm_addr_q + DmWordBits'(1);
                    MODE_STAT: stat_idx_q <= stat_idx_q + 2'd1;
                    default:   ;
                endcase
            end
        end
    end

`ifdef DBG_STAT_CNT_EN
    logic [StatBits-1:0] stat_cnt_q [4];

    // NOTE: only four counters, so the array is reset like ordinary registers rather than left as RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                stat_cnt_q[i] <= '0;
            end
        end else if (cpu_en) begin
            stat_cnt_q[0] <= stat_cnt_q[0] + StatBits'(1);
            if (bus.cpu_is_jump) begin
                stat_cnt_q[1] <= stat_cnt_q[1] + StatBits'(1);
            end
            if (bus.cpu_branched) begin
                stat_cnt_q[2] <= stat_cnt_q[2] + StatBits'(1);
            end
            if (bus.cpu_is_nop) begin
                stat_cnt_q[3] <= stat_cnt_q[3] + StatBits'(1);
            end
        end
    end

    assign stat_value = 32'(stat_cnt_q[stat_idx_q]);
`else
    logic unused_trace;

    assign stat_value   = '0;
    assign unused_trace = ^{bus.cpu_is_jump, bus.cpu_branched, bus.cpu_is_nop};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_value <= '0;
            disp_tag   <= '0;
        end else begin
            case (mode_e'(sel_mode))
                MODE_CORE: begin
                    disp_value <= bus.cpu_display;
                    disp_tag   <= '0;
                end
                MODE_RF: begin
                    disp_value <= bus.cpu_rf_data;
                    disp_tag   <= {3'b000, rf_req_q};
                end
                MODE_DM: begin
                    disp_value <= bus.cpu_dm_data;
                    disp_tag   <= 8'(dm_addr_q);
                end
                MODE_STAT: begin
                    disp_value <= stat_value;
                    disp_tag   <= {6'b000000, stat_idx_q};
                end
                default: begin
                    disp_value <= '0;
                    disp_tag   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_console.sv
// Directed bench for dbg_console: step/run/halt control, scan index wrap, display mux latency
// and statistics (expected counts are zero unless DBG_STAT_CNT_EN is defined).
module tb_dbg_console;

    localparam int DmWordBits = 10;
`ifdef DBG_STAT_CNT_EN
    localparam bit StatEn = 1'b1;
`else
    localparam bit StatEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_run;
    logic        btn_step;
    logic        btn_next;
    logic [1:0]  sel_mode;
    logic [31:0] disp_value;
    logic [7:0]  disp_tag;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt   = 0;
    int en_base;

    dbg_console_if #(.DmWordBits(DmWordBits)) dbg_bus ();

    dbg_console #(
        .DmWordBits(DmWordBits),
        .StatBits  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_run   (btn_run),
        .btn_step  (btn_step),
        .btn_next  (btn_next),
        .sel_mode  (sel_mode),
        .bus       (dbg_bus),
        .disp_value(disp_value),
        .disp_tag  (disp_tag),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Enable cycles counted mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (dbg_bus.cpu_en) en_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  jump_pat;
    logic [7:0]  br_pat;
    logic [7:0]  nop_pat;
    logic [31:0] stat_exp [4];

    initial begin
        rst_n    = 1'b0;
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_next = 1'b0;
        sel_mode = 2'd0;
        dbg_bus.cpu_halt     = 1'b0;
        dbg_bus.cpu_is_jump  = 1'b0;
        dbg_bus.cpu_branched = 1'b0;
        dbg_bus.cpu_is_nop   = 1'b0;
        dbg_bus.cpu_display  = 32'h0;
        dbg_bus.cpu_rf_data  = 32'h0;
        dbg_bus.cpu_dm_data  = 32'h0;

        // Reset state
        repeat (2) tick();
        check("rst_cpu_en",  32'(dbg_bus.cpu_en), 32'd0);
        check("rst_halted",  32'(halted), 32'd0);
        check("rst_rf_req",  32'(dbg_bus.dbg_rf_req), 32'd0);
        check("rst_dm_addr", 32'(dbg_bus.dbg_dm_addr), 32'd0);
        check("rst_disp",    disp_value, 32'd0);
        check("rst_tag",     32'(disp_tag), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("idle_cpu_en", 32'(dbg_bus.cpu_en), 32'd0);

        // Three single steps: one isolated enable cycle each
        en_base = en_cnt;
        for (int i = 0; i < 3; i++) begin
            btn_step = 1'b1;
            tick();
            btn_step = 1'b0;
            check("step_en", 32'(dbg_bus.cpu_en), 32'd1);
            tick();
            check("step_back_pause", 32'(dbg_bus.cpu_en), 32'd0);
        end
        check("step_count", 32'(en_cnt - en_base), 32'd3);

        // Run for exactly 10 cycles
        en_base = en_cnt;
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        repeat (9) tick();
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        check("run_count", 32'(en_cnt - en_base), 32'd10);
        tick();
        check("run_paused", 32'(dbg_bus.cpu_en), 32'd0);
        check("run_count_frozen", 32'(en_cnt - en_base), 32'd10);

        // Cycle counter after 3 steps + 10 run cycles
        sel_mode = 2'd3;
        tick();
        check("stat_cycles_13", disp_value, StatEn ? 32'd13 : 32'd0);
        check("stat_tag0", 32'(disp_tag), 32'd0);

        // Register scan: 33 presses wrap 31 -> 0 -> 1
        sel_mode = 2'd1;
        tick();
        for (int k = 1; k <= 33; k++) begin
            btn_next = 1'b1;
            tick();
            btn_next = 1'b0;
            if (k == 31) check("rf_req_31", 32'(dbg_bus.dbg_rf_req), 32'd31);
            if (k == 32) check("rf_req_wrap", 32'(dbg_bus.dbg_rf_req), 32'd0);
        end
        check("rf_req_1", 32'(dbg_bus.dbg_rf_req), 32'd1);
        check("rf_dm_untouched", 32'(dbg_bus.dbg_dm_addr), 32'd0);
        dbg_bus.cpu_rf_data = 32'hDEADBEEF;
        tick();
        check("rf_disp", disp_value, 32'hDEADBEEF);
        check("rf_tag", 32'(disp_tag), 32'd1);

        // Core display mode ignores btn_next
        sel_mode = 2'd0;
        dbg_bus.cpu_display = 32'h12345678;
        tick();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        check("core_next_ignored", 32'(dbg_bus.dbg_rf_req), 32'd1);
        check("core_disp", disp_value, 32'h12345678);
        check("core_tag", 32'(disp_tag), 32'd0);

        // Memory scan: 1025 presses wrap 1023 -> 0 -> 1
        sel_mode = 2'd2;
        tick();
        for (int k = 1; k <= 1025; k++) begin
            btn_next = 1'b1;
            tick();
            btn_next = 1'b0;
            if (k == 1023) check("dm_addr_max", 32'(dbg_bus.dbg_dm_addr), 32'd1023);
            if (k == 1024) check("dm_addr_wrap", 32'(dbg_bus.dbg_dm_addr), 32'd0);
        end
        check("dm_addr_1", 32'(dbg_bus.dbg_dm_addr), 32'd1);
        dbg_bus.cpu_dm_data = 32'hCAFEF00D;
        tick();
        check("dm_disp", disp_value, 32'hCAFEF00D);
        check("dm_tag", 32'(disp_tag), 32'd1);

        // Press coinciding with a mode change advances the old mode's index
        sel_mode = 2'd1;
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        check("chg_dm_advanced", 32'(dbg_bus.dbg_dm_addr), 32'd2);
        check("chg_rf_kept", 32'(dbg_bus.dbg_rf_req), 32'd1);
        tick();
        check("chg_disp_rf", disp_value, 32'hDEADBEEF);
        check("chg_tag_rf", 32'(disp_tag), 32'd1);

        // btn_run wins over btn_step
        btn_run  = 1'b1;
        btn_step = 1'b1;
        tick();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        check("prio_en0", 32'(dbg_bus.cpu_en), 32'd1);
        tick();
        check("prio_still_run", 32'(dbg_bus.cpu_en), 32'd1);
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        check("prio_paused", 32'(dbg_bus.cpu_en), 32'd0);

        // Asynchronous reset mid-run
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        check("arst_running", 32'(dbg_bus.cpu_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_en_off", 32'(dbg_bus.cpu_en), 32'd0);
        check("arst_rf_req", 32'(dbg_bus.dbg_rf_req), 32'd0);
        check("arst_disp", disp_value, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("arst_paused", 32'(dbg_bus.cpu_en), 32'd0);

        // Statistics over 8 run cycles: jump 2, branched 3, nop 1
        jump_pat = 8'b0010_0010;
        br_pat   = 8'b0100_1001;
        nop_pat  = 8'b1000_0000;
        sel_mode = 2'd3;
        tick();
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dbg_bus.cpu_is_jump  = jump_pat[i];
            dbg_bus.cpu_branched = br_pat[i];
            dbg_bus.cpu_is_nop   = nop_pat[i];
            if (i == 7) btn_run = 1'b1;
            tick();
            btn_run = 1'b0;
        end
        dbg_bus.cpu_is_jump  = 1'b1;
        dbg_bus.cpu_branched = 1'b1;
        dbg_bus.cpu_is_nop   = 1'b1;
        repeat (2) tick();
        dbg_bus.cpu_is_jump  = 1'b0;
        dbg_bus.cpu_branched = 1'b0;
        dbg_bus.cpu_is_nop   = 1'b0;
        stat_exp[0] = StatEn ? 32'd8 : 32'd0;
        stat_exp[1] = StatEn ? 32'd2 : 32'd0;
        stat_exp[2] = StatEn ? 32'd3 : 32'd0;
        stat_exp[3] = StatEn ? 32'd1 : 32'd0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stat_val%0d", k), disp_value, stat_exp[k]);
            check($sformatf("stat_tag%0d", k), 32'(disp_tag), 32'(k));
            btn_next = 1'b1;
            tick();
            btn_next = 1'b0;
            tick();
        end
        check("stat_idx_wrap", 32'(disp_tag), 32'd0);

        // Halt during run
        sel_mode = 2'd0;
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        tick();
        check("halt_pre_run", 32'(dbg_bus.cpu_en), 32'd1);
        dbg_bus.cpu_halt = 1'b1;
        #1;
        check("halt_en_same_cycle", 32'(dbg_bus.cpu_en), 32'd0);
        check("halt_not_yet", 32'(halted), 32'd0);
        tick();
        check("halted_set", 32'(halted), 32'd1);
        dbg_bus.cpu_halt = 1'b0;
        #1;
        check("halted_en_off", 32'(dbg_bus.cpu_en), 32'd0);
        btn_run  = 1'b1;
        btn_step = 1'b1;
        tick();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        tick();
        check("halted_absorb", 32'(halted), 32'd1);
        check("halted_btn_ignored", 32'(dbg_bus.cpu_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
